// File: rtl/xor_parity_scheduler_pkg.sv
// Shared types and default sizing for the XOR parity scheduler.
// The scheduler FSM walks IDLE -> ACCUM -> RESULT -> IDLE once per packet.
package parity_sched_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BEAT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/xor_parity_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after rr_ptr (wrapping) wins.
// Returns the winner both as a one-hot vector and as an index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_req
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest valid requester is the last to win.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_req   = |req;
        sum       = '0;
        idx       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (sum >= (ID_W + 1)'(N_REQ)) begin
                sum = sum - (ID_W + 1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (req[idx]) begin
                grant_oh      = '0;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/xor_parity_scheduler.sv
// Round-robin scheduler sharing one XOR-fold/parity datapath among N_REQ packet requesters.
// Each granted packet is folded beat by beat and reported once on the result port.
module xor_parity_scheduler
    import parity_sched_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BEAT_W = DEF_BEAT_W,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_W-1:0]       res_word,
    output logic                    res_parity,
    output logic [ID_W-1:0]         res_id,
    output logic [BEAT_W-1:0]       res_beats,
    output logic                    busy
);

    // Handshake: a beat moves when req_valid[i] & req_ready[i] at a rising edge, a result
    // moves when res_valid & res_ready; ready never depends on valid in the same cycle.

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     grant;
    logic [N_REQ-1:0]    grant_oh;
    logic [ID_W-1:0]     rr_ptr;
    logic [DATA_W-1:0]   acc;
    logic [BEAT_W-1:0]   beats;

    logic [N_REQ-1:0]    arb_oh;
    logic [ID_W-1:0]     arb_idx;
    logic                any_req;

    logic [DATA_W-1:0]   cur_beat;
    logic                cur_valid;
    logic                cur_last;
    logic [DATA_W-1:0]   acc_next;
    logic [BEAT_W-1:0]   beats_next;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

    // Only the granted lane is observed; other requesters' valid/last are ignored.
    always_comb begin
        cur_beat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                cur_beat = req_data[i*DATA_W +: DATA_W];
            end
        end
        cur_valid  = |(req_valid & grant_oh);
        cur_last   = |(req_last & grant_oh);
        acc_next   = acc ^ cur_beat;
        beats_next = (&beats) ? beats : beats + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        res_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                req_ready = grant_oh;
                if (cur_valid && cur_last) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers load on the last beat so they hold steady outside RESULT.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            grant_oh   <= '0;
            rr_ptr     <= '0;
            acc        <= '0;
            beats      <= '0;
            res_word   <= '0;
            res_parity <= 1'b0;
            res_id     <= '0;
            res_beats  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= arb_idx;
                        grant_oh <= arb_oh;
                        acc      <= '0;
                        beats    <= '0;
                    end
                end
                ACCUM: begin
                    if (cur_valid) begin
                        acc   <= acc_next;
                        beats <= beats_next;
                        if (cur_last) begin
                            res_word   <= acc_next;
                            res_parity <= ^acc_next;
                            res_id     <= grant;
                            res_beats  <= beats_next;
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_parity_scheduler.sv
// Directed bench for xor_parity_scheduler: vector table of single-requester packets
// plus hand sequences for reset, arbitration order, backpressure, stalls and saturation.
module tb_xor_parity_scheduler;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int BEAT_W = 8;
    localparam int EXP_W  = 1 + 2 + BEAT_W + DATA_W;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    res_valid;
    logic                    res_ready;
    logic [DATA_W-1:0]       res_word;
    logic                    res_parity;
    logic [1:0]              res_id;
    logic [BEAT_W-1:0]       res_beats;
    logic                    busy;

    int checks    = 0;
    int errors    = 0;
    int res_count = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [31:0]      beat_buf [300];

    typedef struct packed {
        logic [1:0]       id;
        logic [2:0]       n;
        logic [3:0][31:0] w;
        logic [31:0]      exp_word;
        logic             exp_par;
    } vec_t;

    vec_t vecs [4];

    xor_parity_scheduler #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_word   (res_word),
        .res_parity (res_parity),
        .res_id     (res_id),
        .res_beats  (res_beats),
        .busy       (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] id, input logic [2:0] n,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic [31:0] ew, input logic ep);
        vec_t v;
        v.id       = id;
        v.n        = n;
        v.w[0]     = w0;
        v.w[1]     = w1;
        v.w[2]     = w2;
        v.w[3]     = w3;
        v.exp_word = ew;
        v.exp_par  = ep;
        return v;
    endfunction

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int id, input int n);
        int k;
        for (int b = 0; b < n; b++) begin
            req_valid[id]           = 1'b1;
            req_data[id*32 +: 32]   = beat_buf[b];
            req_last[id]            = (b == n - 1);
            k = 0;
            while (!req_ready[id] && k < 50) begin
                cyc();
                k++;
            end
            if (k >= 50) begin
                chk("beat_accept_timeout", 64'(k), 64'd0);
            end
            cyc();
        end
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic wait_results(input int target);
        int n = 0;
        while (res_count < target && n < 400) begin
            cyc();
            n++;
        end
        if (res_count < target) begin
            chk("result_timeout", 64'(res_count), 64'(target));
        end
    endtask

    function automatic logic [EXP_W-1:0] pack_exp(input logic p, input logic [1:0] id,
                                                  input logic [7:0] beats, input logic [31:0] w);
        return {p, id, beats, w};
    endfunction

    // Scoreboard: every accepted result must match the head of the expected queue
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result_id", 64'(res_id), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("res_word",   64'(res_word),   64'(e[31:0]));
                chk("res_beats",  64'(res_beats),  64'(e[39:32]));
                chk("res_id",     64'(res_id),     64'(e[41:40]));
                chk("res_parity", 64'(res_parity), 64'(e[42]));
                res_count++;
            end
        end
    end

    initial begin
        int base;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        res_ready = 1'b1;

        vecs[0] = mk(2'd1, 3'd1, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
        vecs[1] = mk(2'd2, 3'd4, 32'h1, 32'h1, 32'h1, 32'h80000000, 32'h80000001, 1'b0);
        vecs[2] = mk(2'd0, 3'd3, 32'h12345678, 32'h12345678, 32'h1, 32'h0, 32'h1, 1'b1);
        vecs[3] = mk(2'd3, 3'd2, 32'hFFFF0000, 32'h0000FFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);

        // Reset held two cycles
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_res_valid",  64'(res_valid),  64'd0);
        chk("rst_req_ready",  64'(req_ready),  64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_res_word",   64'(res_word),   64'd0);
        chk("rst_res_parity", 64'(res_parity), 64'd0);
        chk("rst_res_id",     64'(res_id),     64'd0);
        chk("rst_res_beats",  64'(res_beats),  64'd0);

        // Requester 0: 0x1, 0x2, 0x4 back-to-back
        beat_buf[0] = 32'h1;
        beat_buf[1] = 32'h2;
        beat_buf[2] = 32'h4;
        exp_q.push_back(pack_exp(1'b1, 2'd0, 8'd3, 32'h7));
        send_pkt(0, 3);
        chk("t2_res_valid_after_last", 64'(res_valid), 64'd1);
        chk("t2_res_parity", 64'(res_parity), 64'd1);
        chk("t2_req_ready_in_result", 64'(req_ready), 64'd0);
        chk("t2_busy", 64'(busy), 64'd1);
        wait_results(1);

        // Vector table
        for (int v = 0; v < 4; v++) begin
            for (int b = 0; b < 4; b++) beat_buf[b] = vecs[v].w[b];
            base = res_count;
            exp_q.push_back(pack_exp(vecs[v].exp_par, vecs[v].id, 8'(vecs[v].n), vecs[v].exp_word));
            send_pkt(int'(vecs[v].id), int'(vecs[v].n));
            chk("tbl_res_valid_after_last", 64'(res_valid), 64'd1);
            wait_results(base + 1);
        end

        // All four requesters continuously valid with single-beat 0x3 packets
        base = res_count;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h3;
        req_valid = 4'hF;
        req_last  = 4'hF;
        exp_q.push_back(pack_exp(1'b0, 2'd0, 8'd1, 32'h3));
        exp_q.push_back(pack_exp(1'b0, 2'd1, 8'd1, 32'h3));
        exp_q.push_back(pack_exp(1'b0, 2'd2, 8'd1, 32'h3));
        exp_q.push_back(pack_exp(1'b0, 2'd3, 8'd1, 32'h3));
        exp_q.push_back(pack_exp(1'b0, 2'd0, 8'd1, 32'h3));
        wait_results(base + 5);
        req_valid = '0;
        req_last  = '0;
        cyc();
        chk("t3_idle_after_stop", 64'(busy), 64'd0);

        // Requester 2 result held under backpressure while requester 1 waits
        base = res_count;
        res_ready   = 1'b0;
        beat_buf[0] = 32'hFF;
        beat_buf[1] = 32'h0F;
        exp_q.push_back(pack_exp(1'b0, 2'd2, 8'd2, 32'hF0));
        exp_q.push_back(pack_exp(1'b0, 2'd1, 8'd1, 32'h55));
        send_pkt(2, 2);
        req_valid[1]       = 1'b1;
        req_data[32 +: 32] = 32'h55;
        req_last[1]        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_res_valid", 64'(res_valid), 64'd1);
            chk("t4_hold_res_word",  64'(res_word),  64'hF0);
            chk("t4_hold_res_id",    64'(res_id),    64'd2);
            chk("t4_hold_req_ready", 64'(req_ready), 64'd0);
            cyc();
        end
        res_ready = 1'b1;
        cyc();
        chk("t4_bubble_req_ready", 64'(req_ready), 64'd0);
        chk("t4_bubble_busy",      64'(busy),      64'd0);
        cyc();
        chk("t4_grant_r1_ready", 64'(req_ready), 64'b0010);
        cyc();
        req_valid[1] = 1'b0;
        req_last[1]  = 1'b0;
        wait_results(base + 2);

        // Requester 1 stalls mid-packet while requester 3 is valid
        base = res_count;
        exp_q.push_back(pack_exp(1'b1, 2'd1, 8'd3, 32'h70));
        req_valid[1]       = 1'b1;
        req_data[32 +: 32] = 32'h10;
        req_last[1]        = 1'b0;
        cyc();
        chk("t5_grant_r1_ready", 64'(req_ready), 64'b0010);
        cyc();
        req_valid[1]       = 1'b0;
        req_valid[3]       = 1'b1;
        req_data[96 +: 32] = 32'h999;
        req_last[3]        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_stall_req_ready", 64'(req_ready), 64'b0010);
            chk("t5_stall_busy",      64'(busy),      64'd1);
            chk("t5_stall_res_valid", 64'(res_valid), 64'd0);
            cyc();
        end
        req_valid[1]       = 1'b1;
        req_data[32 +: 32] = 32'h20;
        cyc();
        req_data[32 +: 32] = 32'h40;
        req_last[1]        = 1'b1;
        cyc();
        chk("t5_res_valid_after_last", 64'(res_valid), 64'd1);
        req_valid = '0;
        req_last  = '0;
        wait_results(base + 1);

        // Beat counter saturates; XOR keeps folding
        base = res_count;
        for (int b = 0; b < 299; b++) beat_buf[b] = 32'hC3;
        beat_buf[299] = 32'h0F;
        exp_q.push_back(pack_exp(1'b0, 2'd2, 8'd255, 32'hCC));
        send_pkt(2, 300);
        wait_results(base + 1);

        // Reset in the middle of requester 3's packet
        base = res_count;
        req_valid[3]       = 1'b1;
        req_data[96 +: 32] = 32'h1;
        req_last[3]        = 1'b0;
        cyc();
        cyc();
        req_data[96 +: 32] = 32'h2;
        cyc();
        chk("t6_accum_busy", 64'(busy), 64'd1);
        req_data[96 +: 32] = 32'h4;
        req_last[3]        = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req_valid[0]      = 1'b1;
        req_data[0 +: 32] = 32'hABCD;
        req_last[0]       = 1'b1;
        chk("t6_post_rst_busy",      64'(busy),      64'd0);
        chk("t6_post_rst_req_ready", 64'(req_ready), 64'd0);
        chk("t6_post_rst_res_valid", 64'(res_valid), 64'd0);
        exp_q.push_back(pack_exp(1'b0, 2'd0, 8'd1, 32'hABCD));
        cyc();
        chk("t6_grant_r0_ready", 64'(req_ready), 64'b0001);
        cyc();
        req_valid = '0;
        req_last  = '0;
        wait_results(base + 1);
        repeat (3) cyc();

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
